// File: rtl/mtl_frame_prefetcher_if.sv
// ---------------------------------------------------------------------------
// mtl_frame_prefetcher_if
// SDRAM read-side bus between mtl_frame_prefetcher (master) and the SDRAM
// memory interface (slave).
//   mem_address       : 24-bit word address of the read request
//   mem_read          : read request, held with address while stalled
//   mem_waitrequest   : slave stalls the current request
//   mem_readdata      : 32-bit returned word
//   mem_readdatavalid : return strobe, returns arrive in request order
// ---------------------------------------------------------------------------
interface mtl_frame_prefetcher_if;
  logic [23:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_waitrequest,
    input  mem_readdata,
    input  mem_readdatavalid
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_waitrequest,
    output mem_readdata,
    output mem_readdatavalid
  );
endinterface

// File: rtl/mtl_frame_prefetcher.sv
// ---------------------------------------------------------------------------
// mtl_frame_prefetcher
// Streams a frame from SDRAM into a show-ahead FIFO on the MTL pixel clock so
// the LCD timing never sees SDRAM latency or waitrequest stalls.
// Ports:
//   iCLK_33, iRST          : pixel clock, synchronous active-high reset
//   i_load_new             : flush and restart fetch at i_base_address
//   i_base_address         : first word address (sampled with i_load_new)
//   i_max_address          : exclusive end address (sampled with i_load_new)
//   i_read_enable          : pop request from the display controller
//   o_readdata             : FIFO head word, 0 when empty
//   o_underflow            : 1-cycle pulse on a pop of an empty FIFO
//   o_frame_fetched        : every read of the frame issued and returned
//   mem                    : SDRAM read bus (master modport)
//   o_underflow_count      : saturating underflow counter, only present when
//                            UNDERFLOW_COUNT_EN is defined
// All outputs are registered; each *_d is the value the output must show in
// the cycle after the edge, computed from the post-edge state.
// ---------------------------------------------------------------------------
module mtl_frame_prefetcher #(
  parameter int FIFO_DEPTH      = 64,
  parameter int ADDR_STEP       = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    iCLK_33,
  input  logic                    iRST,
  input  logic                    i_load_new,
  input  logic [23:0]             i_base_address,
  input  logic [23:0]             i_max_address,
  input  logic                    i_read_enable,
  output logic [31:0]             o_readdata,
  output logic                    o_underflow,
  output logic                    o_frame_fetched,
  mtl_frame_prefetcher_if.master  mem
`ifdef UNDERFLOW_COUNT_EN
  ,output logic [15:0]            o_underflow_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  // One extra bit so the address cannot wrap past the end of the 24-bit space
  logic [24:0]     addr_q, addr_d;
  logic [23:0]     max_q, max_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            req_q, req_d;
  logic [23:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            underflow_q, underflow_d;
  logic            fetched_q, fetched_d;
  logic [31:0]     fifo_mem_q [FIFO_DEPTH];

  logic            accept_s, ret_eff_s, push_s, pop_s;
  logic [CW:0]     credit_sum_s;

  // Handshake decode: load_new overrides pops and drops a same-cycle return
  always_comb begin
    accept_s    = req_q & ~mem.mem_waitrequest;
    ret_eff_s   = mem.mem_readdatavalid & ((outst_q != '0) | accept_s);
    push_s      = ret_eff_s & ~i_load_new & (state_q != S_DRAIN);
    pop_s       = i_read_enable & ~i_load_new & (count_q != '0);
    underflow_d = i_read_enable & ~i_load_new & (count_q == '0);
  end

  // Next-state, counters, FIFO pointers and registered output values
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    max_d      = max_q;
    outst_d    = outst_q + OW'(accept_s) - OW'(ret_eff_s);
    discard_d  = discard_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    req_d      = 1'b0;
    mem_addr_d = mem_addr_q;
    rdata_d    = 32'h0000_0000;
    fetched_d  = 1'b0;

    if (i_load_new) begin
      max_d     = i_max_address;
      addr_d    = {1'b0, i_base_address};
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      // Everything still in flight (including a read accepted this very
      // cycle) belongs to the old frame and must be dropped.
      discard_d = outst_d;
      if (outst_d != '0) begin
        state_d = S_DRAIN;
      end else if (i_base_address >= i_max_address) begin
        state_d = S_DONE;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      wr_ptr_d = wr_ptr_q + AW'(push_s);
      rd_ptr_d = rd_ptr_q + AW'(pop_s);
      if (accept_s) begin
        addr_d = addr_q + 25'(ADDR_STEP);
      end else begin
        addr_d = addr_q;
      end
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_DRAIN: begin
          discard_d = discard_q - OW'(ret_eff_s);
          if (discard_d != '0) begin
            state_d = S_DRAIN;
          end else if (addr_q >= {1'b0, max_q}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (addr_d >= {1'b0, max_q}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end

    // Credit counts words buffered plus words still coming back
    credit_sum_s = (CW+1)'(count_d) + (CW+1)'(outst_d);
    if (req_q && mem.mem_waitrequest && !i_load_new) begin
      req_d      = 1'b1;
      mem_addr_d = mem_addr_q;
    end else if ((state_d == S_FETCH) && (addr_d < {1'b0, max_d}) &&
                 (credit_sum_s < (CW+1)'(FIFO_DEPTH)) &&
                 (outst_d < OW'(MAX_OUTSTANDING))) begin
      req_d      = 1'b1;
      mem_addr_d = addr_d[23:0];
    end else begin
      req_d      = 1'b0;
      mem_addr_d = mem_addr_q;
    end

    // Show-ahead head; a word written into the head slot bypasses the array
    if (count_d == '0) begin
      rdata_d = 32'h0000_0000;
    end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
      rdata_d = mem.mem_readdata;
    end else begin
      rdata_d = fifo_mem_q[rd_ptr_d];
    end

    fetched_d = (state_d == S_DONE) && (outst_d == '0);
  end

  // Control and output registers
  always_ff @(posedge iCLK_33) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      addr_q      <= 25'd0;
      max_q       <= 24'd0;
      outst_q     <= '0;
      discard_q   <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_q       <= 1'b0;
      mem_addr_q  <= 24'd0;
      rdata_q     <= 32'h0000_0000;
      underflow_q <= 1'b0;
      fetched_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      max_q       <= max_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_q       <= req_d;
      mem_addr_q  <= mem_addr_d;
      rdata_q     <= rdata_d;
      underflow_q <= underflow_d;
      fetched_q   <= fetched_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge iCLK_33) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= mem.mem_readdata;
    end
  end

  assign o_readdata      = rdata_q;
  assign o_underflow     = underflow_q;
  assign o_frame_fetched = fetched_q;
  assign mem.mem_read    = req_q;
  assign mem.mem_address = mem_addr_q;

`ifdef UNDERFLOW_COUNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underflow counter, cleared by a new frame
  always_comb begin
    if (i_load_new) begin
      ucnt_d = 16'h0000;
    end else if (underflow_q && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'h0001;
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Underflow counter register
  always_ff @(posedge iCLK_33) begin
    if (iRST) begin
      ucnt_q <= 16'h0000;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign o_underflow_count = ucnt_q;
`endif

endmodule
